// File: rtl/space_invaders_pkg.sv
// space_invaders_pkg: shared constants and types for the player bullet pool
package space_invaders_pkg;
  localparam int NUM_BULLETS = 4;
  localparam int BULLET_W = 10;
  localparam int BULLET_STEP = 4;
  localparam int Y_START = 440;
  localparam int Y_MIN = 0;
  localparam int COOLDOWN = 15;
  typedef enum logic {IDLE, FLYING} slot_state_t;
  typedef struct packed {
    logic active;
    logic [BULLET_W-1:0] x;
    logic [BULLET_W-1:0] y;
  } bullet_t;
endpackage

// File: rtl/bullet_slot.sv
// bullet_slot: one bullet slot FSM with its X/Y position registers
module bullet_slot
  import space_invaders_pkg::*;
#(
  parameter int STEP = BULLET_STEP,
  parameter int Y0 = Y_START,
  parameter int YLO = Y_MIN
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                spawn_i,
  input  logic [BULLET_W-1:0] spawn_x_i,
  input  logic                kill_i,
  output logic                active_o,
  output logic [BULLET_W-1:0] x_o,
  output logic [BULLET_W-1:0] y_o
);
  localparam logic [BULLET_W-1:0] LIM = BULLET_W'(YLO + STEP);
  localparam logic [BULLET_W-1:0] STEP_V = BULLET_W'(STEP);
  localparam logic [BULLET_W-1:0] Y0_V = BULLET_W'(Y0);
  slot_state_t state_q;
  logic [BULLET_W-1:0] x_q, y_q;
  // spawn from idle; while flying, retire on a hit or before y would pass the top, else climb
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
    end else if (state_q == IDLE) begin
      if (spawn_i) begin
        state_q <= FLYING;
        x_q <= spawn_x_i;
        y_q <= Y0_V;
      end
    end else if (kill_i || y_q < LIM) state_q <= IDLE;
    else y_q <= y_q - STEP_V;
  assign active_o = state_q == FLYING;
  assign x_o = x_q;
  assign y_o = y_q;
endmodule

// File: rtl/player_bullet_scheduler.sv
// player_bullet_scheduler: slot allocation, fire cooldown and hit retirement for player bullets; AUTOFIRE_EN makes firing level-triggered
module player_bullet_scheduler #(
  parameter int NUM_BULLETS = space_invaders_pkg::NUM_BULLETS,
  parameter int COOLDOWN = space_invaders_pkg::COOLDOWN,
  parameter int BULLET_STEP = space_invaders_pkg::BULLET_STEP,
  parameter int Y_START = space_invaders_pkg::Y_START,
  parameter int Y_MIN = space_invaders_pkg::Y_MIN
) (
  input  logic                                             frame_clk,
  input  logic                                             Reset,
  input  logic                                             shoot_req,
  input  logic [9:0]                                       player_x,
  input  logic                                             hit_valid,
  input  logic [$clog2(NUM_BULLETS)-1:0]                   hit_idx,
  output logic [NUM_BULLETS-1:0]                           bullet_active,
  output logic [NUM_BULLETS*space_invaders_pkg::BULLET_W-1:0] bullet_x,
  output logic [NUM_BULLETS*space_invaders_pkg::BULLET_W-1:0] bullet_y,
  output logic                                             fire_ack,
  output logic                                             cooldown_busy
);
  import space_invaders_pkg::*;
  localparam int CW = $clog2(COOLDOWN + 1);
  logic shoot_prev_q, fire_ack_q, trig, fire;
  logic [CW-1:0] count_q, count_d;
  logic [NUM_BULLETS-1:0] idle, spawn, kill;
  bullet_t b [NUM_BULLETS];
  assign idle = ~bullet_active;
`ifdef AUTOFIRE_EN
  assign trig = shoot_req;
`else
  assign trig = shoot_req & ~shoot_prev_q;
`endif
  assign fire = trig && count_q == '0 && |idle;
  assign spawn = fire ? idle & (~idle + NUM_BULLETS'(1)) : '0;
  assign count_d = fire ? CW'(COOLDOWN) : count_q - CW'(count_q != '0);
  // shoot edge history, ack pulse and saturating cooldown
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      shoot_prev_q <= 1'b0;
      fire_ack_q <= 1'b0;
      count_q <= '0;
    end else begin
      shoot_prev_q <= shoot_req;
      fire_ack_q <= fire;
      count_q <= count_d;
    end
  assign fire_ack = fire_ack_q;
  assign cooldown_busy = count_q != '0;
  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    assign kill[g] = hit_valid && int'(hit_idx) == g;
    bullet_slot #(.STEP(BULLET_STEP), .Y0(Y_START), .YLO(Y_MIN)) u_slot (
      .frame_clk(frame_clk),
      .Reset(Reset),
      .spawn_i(spawn[g]),
      .spawn_x_i(player_x),
      .kill_i(kill[g]),
      .active_o(b[g].active),
      .x_o(b[g].x),
      .y_o(b[g].y)
    );
    assign bullet_active[g] = b[g].active;
    assign bullet_x[g*BULLET_W +: BULLET_W] = b[g].x;
    assign bullet_y[g*BULLET_W +: BULLET_W] = b[g].y;
  end
endmodule

// File: tb/tb_player_bullet_scheduler.sv
// tb_player_bullet_scheduler: directed checks of spawn, cooldown, pool full, hits, exit and reset
module tb_player_bullet_scheduler;
  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  logic shoot_req = 1'b0;
  logic [9:0] player_x = '0;
  logic hit_valid = 1'b0;
  logic [1:0] hit_idx = '0;
  logic [3:0] bullet_active;
  logic [39:0] bullet_x, bullet_y;
  logic fire_ack, cooldown_busy;
  int n_cmp = 0;
  int n_err = 0;
  int acks, first_ack;
  player_bullet_scheduler dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .shoot_req(shoot_req),
    .player_x(player_x),
    .hit_valid(hit_valid),
    .hit_idx(hit_idx),
    .bullet_active(bullet_active),
    .bullet_x(bullet_x),
    .bullet_y(bullet_y),
    .fire_ack(fire_ack),
    .cooldown_busy(cooldown_busy)
  );
  always #5 frame_clk = ~frame_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge frame_clk);
  endtask
  function automatic logic [9:0] xs(input int i);
    return bullet_x[i*10 +: 10];
  endfunction
  function automatic logic [9:0] ys(input int i);
    return bullet_y[i*10 +: 10];
  endfunction
  always @(negedge frame_clk)
    for (int i = 0; i < 4; i++)
      if (bullet_active[i]) check("y_bound", 32'(ys(i) <= 10'd440), 1);
  initial begin
    step(2);
    check("rst_active", 32'(bullet_active), 0);
    check("rst_ack", 32'(fire_ack), 0);
    check("rst_busy", 32'(cooldown_busy), 0);
    check("rst_x", bullet_x[31:0], 0);
    check("rst_y", bullet_y[31:0], 0);
    Reset = 1'b0;
    step(1);
    shoot_req = 1'b1; player_x = 10'd320;
    step(1);
    check("t1_active", 32'(bullet_active), 4'b0001);
    check("t1_x0", 32'(xs(0)), 320);
    check("t1_y0", 32'(ys(0)), 440);
    check("t1_ack", 32'(fire_ack), 1);
    check("t1_busy", 32'(cooldown_busy), 1);
    shoot_req = 1'b0;
    step(1);
    check("t1_y0_move", 32'(ys(0)), 436);
    check("t1_ack_drop", 32'(fire_ack), 0);
    step(3);
    shoot_req = 1'b1;
    step(1);
    check("t2_cool_ack", 32'(fire_ack), 0);
    check("t2_cool_active", 32'(bullet_active), 4'b0001);
    shoot_req = 1'b0;
    step(10);
    check("t2_busy_clear", 32'(cooldown_busy), 0);
    shoot_req = 1'b1; player_x = 10'd100;
    step(1);
    check("t2_ack", 32'(fire_ack), 1);
    check("t2_active", 32'(bullet_active), 4'b0011);
    check("t2_x1", 32'(xs(1)), 100);
    check("t2_y1", 32'(ys(1)), 440);
    check("t2_y0", 32'(ys(0)), 376);
    shoot_req = 1'b0;
    step(15);
    shoot_req = 1'b1; player_x = 10'd200;
    step(1);
    check("t3_slot2", 32'(bullet_active), 4'b0111);
    shoot_req = 1'b0;
    step(15);
    shoot_req = 1'b1; player_x = 10'd300;
    step(1);
    check("t3_slot3", 32'(bullet_active), 4'b1111);
    shoot_req = 1'b0;
    step(15);
    check("t3_cool_idle", 32'(cooldown_busy), 0);
    shoot_req = 1'b1;
    step(1);
    check("t3_full_ack", 32'(fire_ack), 0);
    check("t3_full_busy", 32'(cooldown_busy), 0);
    check("t3_full_active", 32'(bullet_active), 4'b1111);
    shoot_req = 1'b0; hit_valid = 1'b1; hit_idx = 2'd2;
    step(1);
    check("t3_hit2", 32'(bullet_active), 4'b1011);
    hit_valid = 1'b0; shoot_req = 1'b1; player_x = 10'd50;
    step(1);
    check("t3_refill_ack", 32'(fire_ack), 1);
    check("t3_refill", 32'(bullet_active), 4'b1111);
    check("t3_refill_x2", 32'(xs(2)), 50);
    shoot_req = 1'b0;
    step(4);
    hit_valid = 1'b1; hit_idx = 2'd1;
    step(1);
    check("t5_hit1", 32'(bullet_active), 4'b1101);
    hit_valid = 1'b0;
    step(10);
    hit_valid = 1'b1; hit_idx = 2'd1; shoot_req = 1'b1; player_x = 10'd77;
    step(1);
    check("t5_idle_hit_spawn", 32'(bullet_active), 4'b1111);
    check("t5_ack", 32'(fire_ack), 1);
    check("t5_x1", 32'(xs(1)), 77);
    check("t5_y1", 32'(ys(1)), 440);
    hit_valid = 1'b0; shoot_req = 1'b0;
    step(28);
    check("t4_y0_top", 32'(ys(0)), 0);
    check("t4_alive_top", 32'(bullet_active[0]), 1);
    step(1);
    check("t4_exit", 32'(bullet_active), 4'b1110);
    check("t4_no_wrap", 32'(ys(0)), 0);
    check("t4_y3", 32'(ys(3)), 188);
    #1 Reset = 1'b1;
    #1;
    check("t6_rst_active", 32'(bullet_active), 0);
    check("t6_rst_y", bullet_y[31:0], 0);
    check("t6_rst_busy", 32'(cooldown_busy), 0);
    step(1);
    Reset = 1'b0;
    step(1);
    shoot_req = 1'b1;
    acks = 0; first_ack = -1;
    for (int f = 0; f < 40; f++) begin
      step(1);
      if (fire_ack) begin
        acks++;
        if (first_ack < 0) first_ack = f;
      end
    end
    shoot_req = 1'b0;
    check("t6_first_ack", 32'(first_ack), 0);
`ifdef AUTOFIRE_EN
    check("t6_held_acks", 32'(acks), 3);
    check("t6_held_active", 32'(bullet_active), 4'b0111);
`else
    check("t6_held_acks", 32'(acks), 1);
    check("t6_held_active", 32'(bullet_active), 4'b0001);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
